// File: rtl/mem_pkg.sv
// Shared definitions for the two-master RAM arbiter: the command encoding,
// the arbiter state encoding and the idle-arbitration helper.
package mem_pkg;

    localparam logic [1:0] MEM_NONE    = 2'b00;
    localparam logic [1:0] MEM_MREAD   = 2'b01;
    localparam logic [1:0] MEM_MWRITE  = 2'b10;
    localparam logic [1:0] MEM_ILLEGAL = 2'b11;

    localparam int MAX_RD_LAT = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_OWN0 = 2'b01,
        ARB_OWN1 = 2'b10
    } arb_state_t;

    // Only MREAD and MWRITE count as requests; NONE and the illegal code do not.
    function automatic logic is_req(input logic [1:0] cmd);
        return (cmd == MEM_MREAD) || (cmd == MEM_MWRITE);
    endfunction

    // Idle arbitration, returned as {valid, winner}. When both masters
    // request, the one that was not granted most recently wins.
    function automatic logic [1:0] pick_idle(input logic req0, input logic req1,
                                             input logic last);
        logic [1:0] res;
        if (req0 && req1) begin
            res = {1'b1, ~last};
        end else if (req0) begin
            res = {1'b1, 1'b0};
        end else if (req1) begin
            res = {1'b1, 1'b1};
        end else begin
            res = {1'b0, 1'b0};
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arbiter_rd_return_pipe.sv
// Read-return pipeline: carries {valid, owner} of each granted read for
// RD_LAT cycles so the returning RAM data can be steered to its master.
module rd_return_pipe
    import mem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_push_valid,
    input  logic i_push_tag,
    output logic o_pop_valid,
    output logic o_pop_tag
);

    // Latency is kept within the supported 1..MAX_RD_LAT range.
    localparam int DEPTH = (RD_LAT < 1) ? 1 : ((RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : RD_LAT);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_tag;

    // Shift the read tags one stage per cycle; reset drops every read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= {DEPTH{1'b0}};
            r_tag   <= {DEPTH{1'b0}};
        end else begin
            r_valid[0] <= i_push_valid;
            r_tag[0]   <= i_push_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
        end
    end

    assign o_pop_valid = r_valid[DEPTH-1];
    assign o_pop_tag   = r_tag[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of the shared instruction/data RAM. Master 0
// is the CPU, master 1 the DMA/debug loader. Ownership is sticky, bounded by
// MAX_HOLD while the other master waits, and read data is routed back to
// its requester RD_LAT cycles after the grant.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        m0_cmd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic [1:0]        m1_cmd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic       w_req0;
    logic       w_req1;
    logic [1:0] w_pick;
    logic       w_win_valid;
    logic       w_win;
    logic       w_same_owner;
    logic       w_other_req;
    logic       w_push;
    logic       w_pop_valid;
    logic       w_pop_tag;
    logic       w_rvalid0;
    logic       w_rvalid1;

    // Pick this cycle's winner: the owner keeps the RAM unless its hold has
    // run out while the other master waits; a non-requesting owner falls back
    // to idle arbitration. Nothing wins during reset.
    always_comb begin
        w_req0      = is_req(m0_cmd);
        w_req1      = is_req(m1_cmd);
        w_pick      = pick_idle(w_req0, w_req1, r_last);
        w_win_valid = 1'b0;
        w_win       = 1'b0;
        if (reset) begin
            w_win_valid = 1'b0;
            w_win       = 1'b0;
        end else begin
            case (r_state)
                ARB_OWN0: begin
                    if (w_req0) begin
                        w_win_valid = 1'b1;
                        w_win       = w_req1 && (r_hold == HOLD_LAST);
                    end else begin
                        w_win_valid = w_pick[1];
                        w_win       = w_pick[0];
                    end
                end
                ARB_OWN1: begin
                    if (w_req1) begin
                        w_win_valid = 1'b1;
                        w_win       = !(w_req0 && (r_hold == HOLD_LAST));
                    end else begin
                        w_win_valid = w_pick[1];
                        w_win       = w_pick[0];
                    end
                end
                default: begin
                    w_win_valid = w_pick[1];
                    w_win       = w_pick[0];
                end
            endcase
        end
    end

    // Next owner state, most recent grantee and hold count.
    always_comb begin
        w_same_owner = ((r_state == ARB_OWN0) && !w_win) || ((r_state == ARB_OWN1) && w_win);
        w_other_req  = w_win ? w_req0 : w_req1;
        w_state_nxt  = ARB_IDLE;
        w_last_nxt   = r_last;
        w_hold_nxt   = {HOLD_W{1'b0}};
        if (w_win_valid) begin
            w_state_nxt = w_win ? ARB_OWN1 : ARB_OWN0;
            w_last_nxt  = w_win;
            if (w_same_owner && w_other_req) begin
                if (r_hold == HOLD_LAST) begin
                    w_hold_nxt = HOLD_LAST;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end else begin
                w_hold_nxt = {HOLD_W{1'b0}};
            end
        end else begin
            w_state_nxt = ARB_IDLE;
            w_last_nxt  = r_last;
            w_hold_nxt  = {HOLD_W{1'b0}};
        end
    end

    // Grants, RAM command mux and read-return steering.
    always_comb begin
        m0_gnt    = w_win_valid && !w_win;
        m1_gnt    = w_win_valid && w_win;
        mem_cmd   = MEM_NONE;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (m1_gnt) begin
            mem_cmd   = m1_cmd;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end else if (m0_gnt) begin
            mem_cmd   = m0_cmd;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else begin
            mem_cmd   = MEM_NONE;
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
        end
        w_push    = w_win_valid && (mem_cmd == MEM_MREAD);
        w_rvalid0 = !reset && w_pop_valid && !w_pop_tag;
        w_rvalid1 = !reset && w_pop_valid && w_pop_tag;
        m0_rvalid = w_rvalid0;
        m1_rvalid = w_rvalid1;
        m0_rdata  = w_rvalid0 ? mem_rdata : r_rdata0;
        m1_rdata  = w_rvalid1 ? mem_rdata : r_rdata1;
    end

    // Arbiter state register; last starts at 1 so master 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_last  <= 1'b1;
            r_hold  <= {HOLD_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Sticky illegal-command flag and per-master copies of the last returned read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err    <= 1'b0;
            r_rdata0 <= {DATA_W{1'b0}};
            r_rdata1 <= {DATA_W{1'b0}};
        end else begin
            if ((m0_cmd == MEM_ILLEGAL) || (m1_cmd == MEM_ILLEGAL)) begin
                r_err <= 1'b1;
            end
            if (w_rvalid0) begin
                r_rdata0 <= mem_rdata;
            end
            if (w_rvalid1) begin
                r_rdata1 <= mem_rdata;
            end
        end
    end

    assign err = r_err;

    rd_return_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rd_return_pipe (
        .clk         (clk),
        .reset       (reset),
        .i_push_valid(w_push),
        .i_push_tag  (w_win),
        .o_pop_valid (w_pop_valid),
        .o_pop_tag   (w_pop_tag)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural RAM with two cycles of read latency,
// per-scenario tasks with inline checks, and a scoreboard of expected read
// returns that is popped whenever either master sees rvalid.
module tb_mem_arbiter;

    localparam int TB_RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m0_cmd, m1_cmd;
    logic [8:0]  m0_addr, m1_addr;
    logic [15:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        err;

    typedef struct {
        bit          tag;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    logic [15:0] ram [0:511] = '{5: 16'hABCD, 16: 16'h1111, 32: 16'h2222,
                                  48: 16'h3333, 64: 16'h4444, default: 16'h0000};
    logic [15:0] rd_q1 = 16'h0000;
    logic [15:0] rd_q2 = 16'h0000;

    mem_arbiter #(
        .ADDR_W(9), .DATA_W(16), .RD_LAT(TB_RD_LAT), .MAX_HOLD(8)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: writes land at the edge, reads return two cycles later.
    always @(posedge clk) begin
        if (mem_cmd == 2'b10) ram[mem_addr] <= mem_wdata;
        rd_q1 <= (mem_cmd == 2'b01) ? ram[mem_addr] : 16'hDEAD;
        rd_q2 <= rd_q1;
    end
    assign mem_rdata = rd_q2;

    // Read-return monitor: every rvalid must match the oldest expected read.
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] got;
        if (m0_rvalid || m1_rvalid) begin
            n_checks++;
            if (m0_rvalid && m1_rvalid) begin
                n_fail++;
                $display("FAIL rvalid_both: m0_rvalid=1 m1_rvalid=1 at cycle %0d, want at most one", cyc);
            end else if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid_unexpected: m0_rvalid=%b m1_rvalid=%b at cycle %0d, want none", m0_rvalid, m1_rvalid, cyc);
            end else begin
                e = sb_q.pop_front();
                got = m1_rvalid ? m1_rdata : m0_rdata;
                if (m1_rvalid !== e.tag || got !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL rd_return: got master %0d data %h cycle %0d, want master %0d data %h cycle %0d",
                             m1_rvalid, got, cyc, e.tag, e.data, e.due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] c0, input logic [8:0] a0, input logic [15:0] w0,
                         input logic [1:0] c1, input logic [8:0] a1, input logic [15:0] w1);
        m0_cmd = c0; m0_addr = a0; m0_wdata = w0;
        m1_cmd = c1; m1_addr = a1; m1_wdata = w1;
    endtask

    task automatic push_exp(input bit tag, input logic [15:0] data);
        exp_t e;
        e.tag = tag; e.data = data; e.due = cyc + TB_RD_LAT;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        drive(2'b00, 9'h000, 16'h0000, 2'b00, 9'h000, 16'h0000);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(2'b01, 9'h005, 16'h0000, 2'b01, 9'h020, 16'h0000);
        tick();
        @(negedge clk);
        n_checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b%b want 00", m0_gnt, m1_gnt); end
        n_checks++; if (mem_cmd !== 2'b00 || mem_addr !== 9'h000) begin n_fail++; $display("FAIL reset_memcmd: got cmd %b addr %h want 00 000", mem_cmd, mem_addr); end
        n_checks++; if (err !== 1'b0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got err %b rv %b%b want 0 00", err, m0_rvalid, m1_rvalid); end
        n_checks++; if (m0_rdata !== 16'h0000 || m1_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0000 0000", m0_rdata, m1_rdata); end
        tick();
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_solo_m0();
        drive(2'b01, 9'h005, 16'h0000, 2'b00, 9'h000, 16'h0000);
        @(negedge clk);
        n_checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL solo_gnt: got %b%b want m0=1 m1=0", m0_gnt, m1_gnt); end
        n_checks++; if (mem_cmd !== 2'b01 || mem_addr !== 9'h005) begin n_fail++; $display("FAIL solo_mem: got cmd %b addr %h want 01 005", mem_cmd, mem_addr); end
        push_exp(1'b0, 16'hABCD);
        tick();
        idle(TB_RD_LAT + 2);
        n_checks++; if (m1_rdata !== 16'h0000) begin n_fail++; $display("FAIL solo_m1_rdata: got %h want 0000", m1_rdata); end
    endtask

    task automatic test_first_contention();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(2'b01, 9'h010, 16'h0000, 2'b01, 9'h020, 16'h0000);
        @(negedge clk);
        n_checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL contend_first: got %b%b want m0 granted", m0_gnt, m1_gnt); end
        push_exp(1'b0, 16'h1111);
        tick();
        drive(2'b00, 9'h000, 16'h0000, 2'b01, 9'h020, 16'h0000);
        @(negedge clk);
        n_checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || mem_addr !== 9'h020) begin n_fail++; $display("FAIL contend_second: got gnt %b%b addr %h want m1 granted addr 020", m0_gnt, m1_gnt, mem_addr); end
        push_exp(1'b1, 16'h2222);
        tick();
        idle(TB_RD_LAT + 2);
    endtask

    task automatic test_hold_limit();
        for (int i = 0; i < 24; i++) begin
            bit owner;
            owner = ((i / 8) % 2) == 1;
            drive(2'b01, 9'h030, 16'h0000, 2'b01, 9'h040, 16'h0000);
            @(negedge clk);
            n_checks++;
            if (m0_gnt !== !owner || m1_gnt !== owner) begin
                n_fail++;
                $display("FAIL hold_limit step %0d: got gnt m0=%b m1=%b want owner m%0d", i, m0_gnt, m1_gnt, owner);
            end
            push_exp(owner, owner ? 16'h4444 : 16'h3333);
            tick();
        end
        idle(TB_RD_LAT + 2);
    endtask

    task automatic test_write_then_read();
        drive(2'b00, 9'h000, 16'h0000, 2'b10, 9'h0FF, 16'h1234);
        @(negedge clk);
        n_checks++; if (m1_gnt !== 1'b1 || mem_cmd !== 2'b10 || mem_addr !== 9'h0FF || mem_wdata !== 16'h1234) begin
            n_fail++; $display("FAIL write_cmd: got gnt %b cmd %b addr %h wdata %h want 1 10 0ff 1234", m1_gnt, mem_cmd, mem_addr, mem_wdata); end
        tick();
        drive(2'b01, 9'h0FF, 16'h0000, 2'b00, 9'h000, 16'h0000);
        @(negedge clk);
        n_checks++; if (m0_gnt !== 1'b1 || mem_cmd !== 2'b01 || mem_addr !== 9'h0FF) begin
            n_fail++; $display("FAIL read_after_write: got gnt %b cmd %b addr %h want 1 01 0ff", m0_gnt, mem_cmd, mem_addr); end
        push_exp(1'b0, 16'h1234);
        tick();
        idle(TB_RD_LAT + 2);
    endtask

    task automatic test_reset_midflight();
        drive(2'b01, 9'h005, 16'h0000, 2'b00, 9'h000, 16'h0000);
        @(negedge clk);
        n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL midflight_gnt: got %b want 1", m0_gnt); end
        tick();
        reset = 1'b1;
        drive(2'b00, 9'h000, 16'h0000, 2'b01, 9'h020, 16'h0000);
        @(negedge clk);
        n_checks++; if (mem_cmd !== 2'b00 || m1_gnt !== 1'b0 || m0_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL midflight_reset: got cmd %b gnt1 %b rv0 %b want 00 0 0", mem_cmd, m1_gnt, m0_rvalid); end
        tick();
        reset = 1'b0;
        drive(2'b01, 9'h010, 16'h0000, 2'b01, 9'h020, 16'h0000);
        @(negedge clk);
        n_checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL midflight_contend: got %b%b want m0 granted", m0_gnt, m1_gnt); end
        push_exp(1'b0, 16'h1111);
        tick();
        drive(2'b00, 9'h000, 16'h0000, 2'b01, 9'h020, 16'h0000);
        @(negedge clk);
        n_checks++; if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL midflight_m1: got %b want 1", m1_gnt); end
        push_exp(1'b1, 16'h2222);
        tick();
        idle(TB_RD_LAT + 2);
    endtask

    task automatic test_illegal();
        drive(2'b00, 9'h000, 16'h0000, 2'b11, 9'h1AB, 16'h5555);
        @(negedge clk);
        n_checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_cmd !== 2'b00) begin
            n_fail++; $display("FAIL illegal_nogrant: got gnt %b%b cmd %b want 00 00", m0_gnt, m1_gnt, mem_cmd); end
        n_checks++; if (mem_addr !== 9'h000 || mem_wdata !== 16'h0000 || err !== 1'b0) begin
            n_fail++; $display("FAIL illegal_same_cycle: got addr %h wdata %h err %b want 000 0000 0", mem_addr, mem_wdata, err); end
        tick();
        idle(0);
        @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err_set: got %b want 1", err); end
        idle(4);
        @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err_sticky: got %b want 1", err); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_clear: got %b want 0", err); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(2'b00, 9'h000, 16'h0000, 2'b00, 9'h000, 16'h0000);
        test_reset();
        test_solo_m0();
        test_first_contention();
        test_hold_limit();
        test_write_then_read();
        test_reset_midflight();
        test_illegal();
        idle(TB_RD_LAT + 2);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_returns: %0d expected reads never returned, want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
